buzzer_music_player: RTL

//  Music sequencer and tone generator on the far side of the buzzer-music register block.

---
 rtl/buzzer_music_player.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/buzzer_music_player.sv
// Song sequencer and square-wave tone generator for the piezo buzzer.
// Steps through a 4-song note ROM and reports the active half-period divider on music_tune.
module buzzer_music_player #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TEMPO_TICKS = 6_250_000,
   parameter int NOTE_GAP    = 500_000,
   parameter int SONG_LEN    = 32
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [1:0]  music_select,
   input  logic        music_start,
   output logic [19:0] music_tune,
   output logic        music_busy,
   output logic        buzzer
);

   localparam int DUR_W = $clog2(8 * TEMPO_TICKS + 1);
   localparam int GAP_W = (NOTE_GAP < 2) ? 1 : $clog2(NOTE_GAP + 1);
   localparam int IDX_W = (SONG_LEN < 2) ? 1 : $clog2(SONG_LEN);

   localparam logic [4:0] CODE_END = 5'd31;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY,
      ST_GAP
   } state_t;

   // Equal-tempered note frequencies in millihertz, code 1 = C4 .. code 30 = F6.
   function automatic longint note_mhz(input int code);
      case (code)
         1:  return 64'd261626;
         2:  return 64'd277183;
         3:  return 64'd293665;
         4:  return 64'd311127;
         5:  return 64'd329628;
         6:  return 64'd349228;
         7:  return 64'd369994;
         8:  return 64'd391995;
         9:  return 64'd415305;
         10: return 64'd440000;
         11: return 64'd466164;
         12: return 64'd493883;
         13: return 64'd523251;
         14: return 64'd554365;
         15: return 64'd587330;
         16: return 64'd622254;
         17: return 64'd659255;
         18: return 64'd698456;
         19: return 64'd739989;
         20: return 64'd783991;
         21: return 64'd830609;
         22: return 64'd880000;
         23: return 64'd932328;
         24: return 64'd987767;
         25: return 64'd1046502;
         26: return 64'd1108731;
         27: return 64'd1174659;
         28: return 64'd1244508;
         29: return 64'd1318510;
         30: return 64'd1396913;
         default: return 64'd0;
      endcase
   endfunction

   // Rounded half period: CLK/(2f) with f in mHz.
   function automatic longint note_div(input int code);
      longint f;
      f = note_mhz(code);
      if (f == 64'd0) begin
         return 64'd0;
      end
      return (longint'(CLK_FREQ_HZ) * 64'd1000 + f) / (64'd2 * f);
   endfunction

   logic [19:0] div_table [32];

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_div
         localparam logic [19:0] DIV_VAL = 20'(note_div(gi));
         assign div_table[gi] = DIV_VAL;
      end
   endgenerate

   state_t            state_q, state_d;
   logic [1:0]        song_q, song_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [19:0]       tune_q, tune_d;
   logic [19:0]       tone_cnt_q, tone_cnt_d;
   logic              buzzer_q, buzzer_d;
   logic              busy_q, busy_d;
   logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              start_q, start_d;

   logic              rise;
   int                rom_idx;
   logic [7:0]        rom_entry;
   logic [4:0]        note_code;
   logic [2:0]        note_dur;
   logic [3:0]        note_units;
   logic              note_end;
   logic [DUR_W-1:0]  dur_load;

   assign rise    = music_start & ~start_q;
   assign rom_idx = int'(index_q);

   // Note ROM: entry = {code, dur}; anything past the written entries reads as END.
   always_comb begin
      rom_entry = {CODE_END, 3'd0};
      case (song_q)
         2'd0: begin
            case (rom_idx)
               0:  rom_entry = {5'd13, 3'd2};
               1:  rom_entry = {5'd17, 3'd1};
               2:  rom_entry = {5'd20, 3'd1};
               3:  rom_entry = {5'd25, 3'd2};
               4:  rom_entry = {5'd0,  3'd1};
               5:  rom_entry = {5'd20, 3'd1};
               6:  rom_entry = {5'd25, 3'd4};
               7:  rom_entry = {5'd0,  3'd2};
               8:  rom_entry = {5'd15, 3'd1};
               9:  rom_entry = {5'd18, 3'd1};
               10: rom_entry = {5'd22, 3'd1};
               11: rom_entry = {5'd27, 3'd2};
               12: rom_entry = {5'd22, 3'd1};
               13: rom_entry = {5'd27, 3'd4};
               14: rom_entry = {5'd0,  3'd2};
               15: rom_entry = {5'd17, 3'd1};
               16: rom_entry = {5'd20, 3'd1};
               17: rom_entry = {5'd24, 3'd1};
               18: rom_entry = {5'd29, 3'd2};
               19: rom_entry = {5'd24, 3'd1};
               20: rom_entry = {5'd29, 3'd0};
               default: rom_entry = {CODE_END, 3'd0};
            endcase
         end
         2'd1: begin
            case (rom_idx)
               0: rom_entry = {5'd24, 3'd1};
               1: rom_entry = {5'd29, 3'd3};
               2: rom_entry = {5'd0,  3'd1};
               3: rom_entry = {5'd24, 3'd1};
               4: rom_entry = {5'd29, 3'd3};
               default: rom_entry = {CODE_END, 3'd0};
            endcase
         end
         2'd2: begin
            case (rom_idx)
               0:  rom_entry = {5'd20, 3'd2};
               1:  rom_entry = {5'd0,  3'd1};
               2:  rom_entry = {5'd15, 3'd2};
               3:  rom_entry = {5'd0,  3'd1};
               4:  rom_entry = {5'd13, 3'd4};
               5:  rom_entry = {5'd11, 3'd2};
               6:  rom_entry = {5'd9,  3'd2};
               7:  rom_entry = {5'd8,  3'd2};
               8:  rom_entry = {5'd6,  3'd2};
               9:  rom_entry = {5'd1,  3'd0};
               default: rom_entry = {CODE_END, 3'd0};
            endcase
         end
         default: begin
            case (rom_idx)
               0: rom_entry = {5'd10, 3'd1};
               1: rom_entry = {5'd0,  3'd1};
               2: rom_entry = {5'd22, 3'd2};
               default: rom_entry = {CODE_END, 3'd0};
            endcase
         end
      endcase
   end

   assign note_code  = rom_entry[7:3];
   assign note_dur   = rom_entry[2:0];
   assign note_units = (note_dur == 3'd0) ? 4'd8 : {1'b0, note_dur};
   assign note_end   = (note_code == CODE_END) || (index_q == IDX_W'(SONG_LEN - 1));
   assign dur_load   = DUR_W'(note_units) * DUR_W'(TEMPO_TICKS) - DUR_W'(NOTE_GAP);

   always_comb begin
      state_d    = state_q;
      song_d     = song_q;
      index_d    = index_q;
      tune_d     = tune_q;
      tone_cnt_d = tone_cnt_q;
      buzzer_d   = buzzer_q;
      dur_cnt_d  = dur_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      start_d    = music_start;

      if (state_q == ST_IDLE) begin
         if (rise) begin
            song_d  = music_select;
            index_d = '0;
            state_d = ST_LOAD;
         end
      end else if (!music_start) begin
         // Stop overrides every other transition.
         state_d    = ST_IDLE;
         tune_d     = '0;
         buzzer_d   = 1'b0;
         tone_cnt_d = '0;
         index_d    = '0;
      end else if (rise) begin
         song_d     = music_select;
         index_d    = '0;
         state_d    = ST_LOAD;
         tune_d     = '0;
         buzzer_d   = 1'b0;
         tone_cnt_d = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (note_end) begin
                  index_d = '0;
                  // An empty song would otherwise spin in LOAD forever.
                  if (index_q == '0) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tune_d     = div_table[note_code];
                  tone_cnt_d = '0;
                  buzzer_d   = 1'b0;
                  dur_cnt_d  = dur_load;
                  state_d    = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (tune_q != '0) begin
                  if (tone_cnt_q >= tune_q - 20'd1) begin
                     tone_cnt_d = '0;
                     buzzer_d   = ~buzzer_q;
                  end else begin
                     tone_cnt_d = tone_cnt_q + 20'd1;
                  end
               end
               if (dur_cnt_q <= DUR_W'(1)) begin
                  tune_d     = '0;
                  buzzer_d   = 1'b0;
                  tone_cnt_d = '0;
                  gap_cnt_d  = GAP_W'(NOTE_GAP);
                  state_d    = ST_GAP;
               end else begin
                  dur_cnt_d = dur_cnt_q - DUR_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt_q <= GAP_W'(1)) begin
                  index_d = index_q + IDX_W'(1);
                  state_d = ST_LOAD;
               end else begin
                  gap_cnt_d = gap_cnt_q - GAP_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         song_q     <= '0;
         index_q    <= '0;
         tune_q     <= '0;
         tone_cnt_q <= '0;
         buzzer_q   <= 1'b0;
         busy_q     <= 1'b0;
         dur_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         song_q     <= song_d;
         index_q    <= index_d;
         tune_q     <= tune_d;
         tone_cnt_q <= tone_cnt_d;
         buzzer_q   <= buzzer_d;
         busy_q     <= busy_d;
         dur_cnt_q  <= dur_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         start_q    <= start_d;
      end
   end

   assign music_tune = tune_q;
   assign music_busy = busy_q;
   assign buzzer     = buzzer_q;

endmodule
